instr_queue_dual_port: RTL

- Circular instruction FIFO at the front end. Serves as the responder for both dispatch units' instruction-request handshakes.
- A loader (fetch stage or bench) pushes 32-bit RISC-V instructions.
- Each dispatch unit pulses its read enable and later receives one instruction plus a one-cycle result_ready strobe.
- Port 0 is the priority dispatch unit: it always receives the older instruction when both ports are served in the same cycle.

---
 rtl/instr_queue_if.sv | 37 +++
 rtl/instr_queue_dual_port.sv | 133 +++++++++++++
 2 files changed

// File: rtl/instr_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_queue_if                                                             |
// | Loader push port and dual dispatch request/response signals for the queue. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface instr_queue_if #(
  parameter int DEPTH = 8
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_en;
  logic [31:0]       wr_instr;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              flush;
  logic              rd_en0;
  logic [31:0]       instr_out0;
  logic              result_ready0;
  logic              rd_en1;
  logic [31:0]       instr_out1;
  logic              result_ready1;

  // Loader and dispatch units side
  modport master (
    output wr_en, wr_instr, flush, rd_en0, rd_en1,
    input  full, empty, count, instr_out0, result_ready0, instr_out1, result_ready1
  );

  // Queue side
  modport slave (
    input  wr_en, wr_instr, flush, rd_en0, rd_en1,
    output full, empty, count, instr_out0, result_ready0, instr_out1, result_ready1
  );
endinterface
`default_nettype wire

// File: rtl/instr_queue_dual_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_queue_dual_port                                                      |
// | Circular instruction FIFO answering two dispatch units; port 0 gets the    |
// | older entry. Optional macro IQ_NOP_ON_EMPTY_EN answers starved requests    |
// | with a NOP instead of holding them pending.                                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module instr_queue_dual_port #(
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  instr_queue_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [31:0]      C_NOP_INSTR = 32'h0000_0013;
  localparam logic [CNT_W-1:0] C_DEPTH     = CNT_W'(DEPTH);

  logic [31:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_head;
  logic [ADDR_W-1:0] r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_pend0;
  logic              r_pend1;
  logic              r_rr0;
  logic              r_rr1;
  logic [31:0]       r_out0;
  logic [31:0]       r_out1;

  logic              w_full;
  logic              w_req0;
  logic              w_req1;
  logic              w_serve0;
  logic              w_serve1;
  logic              w_push;
  logic              w_nop0;
  logic              w_nop1;
  logic              w_pend0_next;
  logic              w_pend1_next;
  logic [CNT_W-1:0]  w_need1;
  logic [ADDR_W-1:0] w_head_p1;
  logic [ADDR_W-1:0] w_rd_idx1;
  logic [ADDR_W-1:0] w_head_next;
  logic [CNT_W-1:0]  w_count_next;

  assign w_full = (r_count == C_DEPTH);

  // Service decisions use the registered count, so a same-edge push is never popped
  assign w_req0   = bus.rd_en0 | r_pend0;
  assign w_req1   = bus.rd_en1 | r_pend1;
  assign w_serve0 = w_req0 && (r_count != '0);
  assign w_need1  = w_serve0 ? CNT_W'(2) : CNT_W'(1);
  assign w_serve1 = w_req1 && (r_count >= w_need1);
  assign w_push   = bus.wr_en && !w_full && !bus.flush;

  assign w_head_p1    = r_head + ADDR_W'(1);
  assign w_rd_idx1    = w_serve0 ? w_head_p1 : r_head;
  assign w_head_next  = r_head + ADDR_W'(w_serve0) + ADDR_W'(w_serve1);
  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_serve0) - CNT_W'(w_serve1);

`ifdef IQ_NOP_ON_EMPTY_EN
  assign w_nop0       = w_req0 && !w_serve0;
  assign w_nop1       = w_req1 && !w_serve1;
  assign w_pend0_next = 1'b0;
  assign w_pend1_next = 1'b0;
`else
  assign w_nop0       = 1'b0;
  assign w_nop1       = 1'b0;
  assign w_pend0_next = w_req0 && !w_serve0;
  assign w_pend1_next = w_req1 && !w_serve1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_pend0 <= 1'b0;
      r_pend1 <= 1'b0;
      r_rr0   <= 1'b0;
      r_rr1   <= 1'b0;
      r_out0  <= '0;
      r_out1  <= '0;
    end else if (bus.flush) begin
      // Branch recovery drops everything except the last delivered instructions
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_pend0 <= 1'b0;
      r_pend1 <= 1'b0;
      r_rr0   <= 1'b0;
      r_rr1   <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + ADDR_W'(1);
      end
      r_head  <= w_head_next;
      r_count <= w_count_next;
      r_pend0 <= w_pend0_next;
      r_pend1 <= w_pend1_next;
      r_rr0   <= w_serve0 | w_nop0;
      r_rr1   <= w_serve1 | w_nop1;
      if (w_serve0) begin
        r_out0 <= r_mem[r_head];
      end else if (w_nop0) begin
        r_out0 <= C_NOP_INSTR;
      end
      if (w_serve1) begin
        r_out1 <= r_mem[w_rd_idx1];
      end else if (w_nop1) begin
        r_out1 <= C_NOP_INSTR;
      end
    end
  end

  // Storage is never reset; occupancy is tracked solely by the pointers and count
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_tail] <= bus.wr_instr;
    end
  end

  assign bus.full          = w_full;
  assign bus.empty         = (r_count == '0);
  assign bus.count         = r_count;
  assign bus.instr_out0    = r_out0;
  assign bus.result_ready0 = r_rr0;
  assign bus.instr_out1    = r_out1;
  assign bus.result_ready1 = r_rr1;
endmodule
`default_nettype wire
